cc_miss_request_unit: RTL
=========================

// Module: cc_miss_request_unit
// PURPOSE
//  Upstream neighbour of the cache data-fill stage. Accepts a miss from the tag-compare stage,
//  pushes the miss address into the miss-addr FIFO (consumed by the fill unit), and issues one
//  AXI AR burst (8 x 64-bit, WRAP, critical-word-first). Tracks outstanding line fills and
//  throttles new misses when the FIFO is full or the outstanding limit is reached.
// PARAMETERS
//  MAX_OUTSTANDING  4  max line fills in flight (accepted, last R beat not yet seen); range 1..7
// PORTS
//  clk                     in   1   clock; all logic on posedge
//  rst_n                   in   1   synchronous, active-low reset
//  miss_req_valid_i        in   1   miss request valid from tag compare
//  miss_req_addr_i         in   32  miss byte address: [31:15] tag, [14:6] index, [5:3] word
//  miss_req_ready_o        out  1   miss accepted when valid & ready
//  miss_addr_fifo_full_i   in   1   miss-addr FIFO full
//  miss_addr_fifo_wren_o   out  1   FIFO push strobe
//  miss_addr_fifo_wdata_o  out  32  pushed address (= miss_req_addr_i, unmodified)
//  mem_arvalid_o           out  1   AXI AR valid
//  mem_arready_i           in   1   AXI AR ready
//  mem_araddr_o            out  32  {addr[31:3],3'b000}
//  mem_arlen_o             out  4   constant 4'd7 (8 beats)
//  mem_arsize_o            out  3   constant 3'b011 (8 bytes)
//  mem_arburst_o           out  2   constant 2'b10 (WRAP)
//  mem_rvalid_i            in   1   AXI R valid (monitored only)
//  mem_rready_i            in   1   AXI R ready (monitored only)
//  mem_rlast_i             in   1   AXI R last (monitored only)
//  outstanding_o           out  3   current in-flight fill count
//  protocol_err_o          out  1   sticky: rlast handshake seen while outstanding==0
// BEHAVIOUR
//  Reset: state=IDLE; arvalid=0, araddr=0, fifo_wren=0, ready=0 during reset, outstanding=0,
//   protocol_err=0. Reset mid-burst abandons AR immediately (arvalid low next cycle).
//  FSM: IDLE --accept--> AR_REQ --arvalid&arready--> IDLE. No other states.
//  miss_req_ready_o = (state==IDLE) & !miss_addr_fifo_full_i & (outstanding < MAX_OUTSTANDING);
//   combinational, must not depend on miss_req_valid_i.
//  accept = valid & ready. fifo_wren_o = accept (same cycle, combinational); fifo_wdata_o =
//   miss_req_addr_i. Exactly one push per accepted miss, never a push without an AR.
//  On accept: araddr register <= {addr[31:3],3'b0}; next cycle arvalid=1 (latency 1).
//  AR_REQ: arvalid held high, araddr/len/size/burst stable until arready; arready may be high
//   on first cycle (AR handshake 1 cycle after accept). Ignores arready in IDLE.
//  Throughput: at most one accept per 2 cycles (no accept in AR_REQ).
//  outstanding: +1 on accept, -1 on rvalid&rready&rlast; both same cycle -> unchanged.
//   Never exceeds MAX_OUTSTANDING (guaranteed by ready). Decrement at 0 -> stays 0,
//   protocol_err_o set next cycle and held until reset.
//  Non-last R beats do not affect state. R channel never back-pressured by this block.
// STRUCTURE
//  cc_pkg (shared): AXI_BURST_WRAP=2'b10, CC_ARLEN=4'd7, CC_ARSIZE=3'b011, address field
//   slices (TAG 31:15, IDX 14:6, WORD 5:3), miss_req_state_t enum {IDLE, AR_REQ}.
//  Sub-module: cc_outstanding_counter (inc/dec/sat-at-0, err flag, MAX param) instantiated once.
// TESTING
//  1 addr 0x0001_2348, arready=1 immediately -> push same cycle, next cycle arvalid with
//    araddr=0x0001_2348, arlen=7, arsize=3, arburst=2; outstanding=1.
//  2 arready held low 5 cycles -> arvalid/araddr stable 5 cycles, ready=0 throughout, no 2nd push.
//  3 Four back-to-back misses, no R traffic -> outstanding=4, ready=0 for 5th; one rlast beat
//    -> outstanding=3, ready=1 next cycle.
//  4 fifo_full=1 with valid=1 -> no push, no AR; deassert full -> accept next cycle.
//  5 accept and rlast handshake same cycle at outstanding=2 -> stays 2; rlast at 0 ->
//    stays 0, protocol_err_o=1 until rst_n low.
//  6 rst_n low while arvalid=1 -> arvalid=0, outstanding=0 next cycle; new miss accepted after.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI burst constants,
// miss address field positions and the miss request FSM encoding.
package cc_pkg;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [3:0] CC_ARLEN       = 4'd7;
    localparam logic [2:0] CC_ARSIZE      = 3'b011;

    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 15;
    localparam int IDX_MSB  = 14;
    localparam int IDX_LSB  = 6;
    localparam int WORD_MSB = 5;
    localparam int WORD_LSB = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        AR_REQ = 1'b1
    } miss_req_state_t;

    // Critical word first: keep tag/index/word, drop the byte offset.
    function automatic logic [31:0] cc_beat_addr(input logic [31:0] a);
        return {a[31:WORD_LSB], 3'b000};
    endfunction

endpackage

// File: rtl/cc_outstanding_counter.sv
// Count of line fills in flight; an rlast seen with nothing
// in flight is ignored and raises a sticky error flag.
module cc_outstanding_counter #(
    parameter int MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [2:0] count,
    output logic       at_limit,
    output logic       err
);

    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       err_q;
    logic       err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (dec && (count_q == 3'd0)) begin
            err_d = 1'b1;
            if (inc) begin
                count_d = count_q + 3'd1;
            end
        end else if (inc && !dec) begin
            count_d = count_q + 3'd1;
        end else if (dec && !inc) begin
            count_d = count_q - 3'd1;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q >= 3'(MAX));
    assign err      = err_q;

endmodule

// File: rtl/cc_miss_request_unit.sv
// Accepts a cache miss, pushes its address to the fill FIFO and
// issues one 8-beat WRAP AR burst; throttles on FIFO full / fill limit.
module cc_miss_request_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_req_valid_i,
    input  logic [31:0] miss_req_addr_i,
    output logic        miss_req_ready_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rready_i,
    input  logic        mem_rlast_i,
    output logic [2:0]  outstanding_o,
    output logic        protocol_err_o
);

    miss_req_state_t state_q;
    miss_req_state_t state_d;
    logic [31:0]     araddr_q;
    logic            accept;
    logic            rlast_hs;
    logic            at_limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = AR_REQ;
            AR_REQ:  if (mem_arready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        miss_req_ready_o = rst_n
                         & (state_q == IDLE)
                         & !miss_addr_fifo_full_i
                         & !at_limit;
        accept                 = miss_req_valid_i & miss_req_ready_o;
        miss_addr_fifo_wren_o  = accept;
        miss_addr_fifo_wdata_o = miss_req_addr_i;
        mem_arvalid_o          = (state_q == AR_REQ);
        mem_araddr_o           = araddr_q;
        mem_arlen_o            = CC_ARLEN;
        mem_arsize_o           = CC_ARSIZE;
        mem_arburst_o          = AXI_BURST_WRAP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            araddr_q <= 32'd0;
        end else if (accept) begin
            araddr_q <= cc_beat_addr(miss_req_addr_i);
        end
    end

    assign rlast_hs = mem_rvalid_i & mem_rready_i & mem_rlast_i;

    cc_outstanding_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (accept),
        .dec      (rlast_hs),
        .count    (outstanding_o),
        .at_limit (at_limit),
        .err      (protocol_err_o)
    );

endmodule
